// File: rtl/internal_pkg.sv
// Shared types for the CSR/MMIO slice: write packet, job descriptor,
// job-controller register offsets and FSM states.
package internal_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } t_if_internal;

    typedef struct packed {
        logic [63:0] src;
        logic [63:0] dst;
        logic [31:0] len;
    } t_job_desc;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_DONE
    } t_job_state;

    localparam logic [ADDR_W-1:0] OFF_SRC   = 16'd0;
    localparam logic [ADDR_W-1:0] OFF_DST   = 16'd2;
    localparam logic [ADDR_W-1:0] OFF_LEN   = 16'd4;
    localparam logic [ADDR_W-1:0] OFF_START = 16'd6;
    localparam logic [ADDR_W-1:0] OFF_CLEAR = 16'd8;

endpackage

// File: rtl/mmio_job_ctrl.sv
// MMIO job controller: decodes job register writes, offers one descriptor
// to the engine, tracks completion and busy cycles for host polling.
// Ports: clk, reset (sync, active-high); pkt_in (MMIO write packet);
//   job_valid/job_ready + job_src/job_dst/job_len (descriptor handshake);
//   job_done (engine pulse); sync, busy_cycles, start_err (status).
module mmio_job_ctrl
    import internal_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_DW = 16'h100,
    parameter int                CYC_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  t_if_internal     pkt_in,
    output logic             job_valid,
    input  logic             job_ready,
    output logic [63:0]      job_src,
    output logic [63:0]      job_dst,
    output logic [31:0]      job_len,
    input  logic             job_done,
    output logic             sync,
    output logic [CYC_W-1:0] busy_cycles,
    output logic             start_err
);

    t_job_state state, state_nxt;
    t_job_desc  shadow, job;

    logic [ADDR_W-1:0] off;
    logic wr_src, wr_dst, wr_len, wr_start, wr_clear;
    logic start_ok, start_bad, done_ok, cnt_en, clr_done;
    logic [CYC_W-1:0] cyc;
    logic sync_q, err_q;

    // Addresses below BASE_DW wrap to large offsets and never decode.
    assign off = pkt_in.addr - BASE_DW;

    always_comb begin
        wr_src   = 1'b0;
        wr_dst   = 1'b0;
        wr_len   = 1'b0;
        wr_start = 1'b0;
        wr_clear = 1'b0;
        if (pkt_in.valid) begin
            unique case (1'b1)
                (off == OFF_SRC):   wr_src   = 1'b1;
                (off == OFF_DST):   wr_dst   = 1'b1;
                (off == OFF_LEN):   wr_len   = 1'b1;
                (off == OFF_START): wr_start = 1'b1;
                (off == OFF_CLEAR): wr_clear = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        done_ok   = 1'b0;
        cnt_en    = 1'b0;
        clr_done  = 1'b0;
        job_valid = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (wr_start) begin
                    start_ok  = 1'b1;
                    state_nxt = (shadow.len != 32'd0) ? S_ISSUE : S_DONE;
                end else if (wr_clear && state == S_DONE) begin
                    clr_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                job_valid = 1'b1;
                start_bad = wr_start;
                if (job_ready) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                start_bad = wr_start;
                if (job_done) begin
                    done_ok   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            job    <= '0;
            cyc    <= '0;
            sync_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (wr_src) shadow.src <= pkt_in.data;
            if (wr_dst) shadow.dst <= pkt_in.data;
            if (wr_len) shadow.len <= pkt_in.data[31:0];
            // A zero-length job completes immediately, so sync is
            // raised on entry to DONE rather than left cleared.
            if (start_ok) begin
                job    <= shadow;
                cyc    <= '0;
                sync_q <= (shadow.len == 32'd0);
            end
            if (done_ok)  sync_q <= 1'b1;
            if (clr_done) sync_q <= 1'b0;
            if (cnt_en && cyc != {CYC_W{1'b1}}) begin
                cyc <= cyc + 1'b1;
            end
            if (start_bad) err_q <= 1'b1;
            if (wr_clear)  err_q <= 1'b0;
        end
    end

    assign job_src     = job.src;
    assign job_dst     = job.dst;
    assign job_len     = job.len;
    assign sync        = sync_q;
    assign busy_cycles = cyc;
    assign start_err   = err_q;

endmodule
